// File: rtl/alu_pkg.sv
// Shared op-code and sequencer-state encodings for the ALU and the control decoder.
package alu_pkg;

  typedef enum logic [2:0] {
    ADD = 3'b000,
    SUB = 3'b001,
    AND = 3'b010,
    OR  = 3'b011,
    XOR = 3'b100,
    SHL = 3'b101,
    SHR = 3'b110,
    MUL = 3'b111
  } alu_op_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } alu_state_t;

  function automatic logic is_shift(input alu_op_t op);
    return (op == SHL) || (op == SHR);
  endfunction

endpackage

// File: rtl/alu_seq_if.sv
// Request/response bundle between the sequencer (master) and alu_seq (slave).
interface alu_seq_if #(parameter int WIDTH = 16);

  logic             in_valid;
  logic             in_ready;
  logic [2:0]       alu_op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             out_valid;
  logic [WIDTH-1:0] result;
  logic             z;
  logic             n;
  logic             c;
  logic             v;

  modport master (
    output in_valid, alu_op, a, b,
    input  in_ready, out_valid, result, z, n, c, v
  );

  modport slave (
    input  in_valid, alu_op, a, b,
    output in_ready, out_valid, result, z, n, c, v
  );

endinterface

// File: rtl/alu_logic_core.sv
// Combinational single-cycle path: ADD/SUB/AND/OR/XOR with carry/borrow and signed overflow.
// No state; other op codes yield zero result and flags.
module alu_logic_core
  import alu_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  alu_op_t          op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] y,
  output logic             c,
  output logic             v
);

  logic [WIDTH:0] sum;
  logic [WIDTH:0] dif;

  assign sum = {1'b0, a} + {1'b0, b};
  // Top bit of the widened difference is the unsigned borrow.
  assign dif = {1'b0, a} - {1'b0, b};

  always_comb begin
    y = '0;
    c = 1'b0;
    v = 1'b0;
    case (op)
      ADD: begin
        y = sum[WIDTH-1:0];
        c = sum[WIDTH];
        v = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
      end
      SUB: begin
        y = dif[WIDTH-1:0];
        c = dif[WIDTH];
        v = (a[WIDTH-1] != b[WIDTH-1]) && (dif[WIDTH-1] != a[WIDTH-1]);
      end
      AND:     y = a & b;
      OR:      y = a | b;
      XOR:     y = a ^ b;
      default: y = '0;
    endcase
  end

endmodule

// File: rtl/alu_seq.sv
// Multi-cycle ALU: logic ops in 1 cycle, shifts in count cycles, MUL in WIDTH cycles to out_valid.
// in_ready only in IDLE; one request in flight, result held until the next completion.
module alu_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic       clk,
  input  logic       rst,
  alu_seq_if.slave   bus
);

  localparam int SHW = $clog2(WIDTH);
  localparam int CW  = SHW + 1;
  localparam logic [CW-1:0] CNT_MUL = CW'(WIDTH);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  alu_state_t state, state_nx;
  alu_op_t    op_in, op_q, op_cur;

  logic [WIDTH-1:0]   sh_q, sh_src, sh_nx;
  logic [2*WIDTH-1:0] mcand_q, mcand_src;
  logic [2*WIDTH-1:0] acc_q, acc_src, acc_nx;
  logic [WIDTH-1:0]   mplier_q, mplier_src;
  logic [CW-1:0]      cnt_q, cnt_src;
  logic [SHW-1:0]     shamt;

  logic             idle, accept, iterative, last_step, shift_out;
  logic             step_en, wr_en;
  logic [WIDTH-1:0] res_nx, core_y;
  logic             c_nx, v_nx, core_c, core_v;
  logic [WIDTH-1:0] result_q;
  logic             c_q, v_q;

  assign op_in     = alu_op_t'(bus.alu_op);
  assign shamt     = bus.b[SHW-1:0];
  assign idle      = (state == IDLE);
  assign accept    = idle && bus.in_valid;
  assign op_cur    = idle ? op_in : op_q;
  assign iterative = (op_in == MUL) || (is_shift(op_in) && (shamt != '0));

  alu_logic_core #(.WIDTH(WIDTH)) u_core (
    .op (op_in),
    .a  (bus.a),
    .b  (bus.b),
    .y  (core_y),
    .c  (core_c),
    .v  (core_v)
  );

  // The first iteration runs on the accept edge straight from the bus,
  // which is what makes a count-N shift finish N cycles after acceptance.
  assign sh_src     = idle ? bus.a : sh_q;
  assign mcand_src  = idle ? {{WIDTH{1'b0}}, bus.a} : mcand_q;
  assign mplier_src = idle ? bus.b : mplier_q;
  assign acc_src    = idle ? '0 : acc_q;
  assign cnt_src    = idle ? ((op_in == MUL) ? CNT_MUL : {1'b0, shamt}) : cnt_q;

  assign sh_nx     = (op_cur == SHL) ? {sh_src[WIDTH-2:0], 1'b0} : {1'b0, sh_src[WIDTH-1:1]};
  assign shift_out = (op_cur == SHL) ? sh_src[WIDTH-1] : sh_src[0];
  assign acc_nx    = acc_src + (mplier_src[0] ? mcand_src : '0);
  assign last_step = (cnt_src == CNT_ONE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    step_en  = 1'b0;
    wr_en    = 1'b0;
    res_nx   = is_shift(op_in) ? bus.a : core_y;
    c_nx     = core_c;
    v_nx     = core_v;
    case (state)
      IDLE: begin
        if (bus.in_valid) begin
          if (iterative) begin
            step_en  = 1'b1;
            state_nx = RUN;
          end else begin
            wr_en    = 1'b1;
            state_nx = DONE;
          end
        end
      end
      RUN:     step_en  = 1'b1;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase

    if (step_en && last_step) begin
      wr_en    = 1'b1;
      state_nx = DONE;
      if (op_cur == MUL) begin
        res_nx = acc_nx[WIDTH-1:0];
        c_nx   = |acc_nx[2*WIDTH-1:WIDTH];
        v_nx   = |acc_nx[2*WIDTH-1:WIDTH];
      end else begin
        res_nx = sh_nx;
        c_nx   = shift_out;
        v_nx   = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_q     <= ADD;
      sh_q     <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      result_q <= '0;
      c_q      <= 1'b0;
      v_q      <= 1'b0;
    end else begin
      if (accept) op_q <= op_in;
      if (step_en) begin
        sh_q     <= sh_nx;
        mcand_q  <= mcand_src << 1;
        mplier_q <= mplier_src >> 1;
        acc_q    <= acc_nx;
        cnt_q    <= cnt_src - CNT_ONE;
      end
      if (wr_en) begin
        result_q <= res_nx;
        c_q      <= c_nx;
        v_q      <= v_nx;
      end
    end
  end

  assign bus.in_ready  = idle;
  assign bus.out_valid = (state == DONE);
  assign bus.result    = result_q;
  assign bus.z         = (result_q == '0);
  assign bus.n         = result_q[WIDTH-1];
  assign bus.c         = c_q;
  assign bus.v         = v_q;

endmodule

// File: tb/tb_alu_seq.sv
// Directed bench for alu_seq at WIDTH 16, 8 and 32 sharing one stimulus bus.
module tb_alu_seq;
  import alu_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [63:0] a_s, b_s;
  logic [2:0]  op_s;
  logic [2:0]  iv;
  logic [1:0]  sel;

  logic        o_rdy, o_vld, o_z, o_n, o_c, o_v;
  logic [63:0] o_res;

  int n_tests = 0;
  int n_fail  = 0;

  alu_seq_if #(.WIDTH(16)) i16 ();
  alu_seq_if #(.WIDTH(8))  i8  ();
  alu_seq_if #(.WIDTH(32)) i32 ();

  assign i16.in_valid = iv[0];
  assign i16.alu_op   = op_s;
  assign i16.a        = a_s[15:0];
  assign i16.b        = b_s[15:0];
  assign i8.in_valid  = iv[1];
  assign i8.alu_op    = op_s;
  assign i8.a         = a_s[7:0];
  assign i8.b         = b_s[7:0];
  assign i32.in_valid = iv[2];
  assign i32.alu_op   = op_s;
  assign i32.a        = a_s[31:0];
  assign i32.b        = b_s[31:0];

  alu_seq #(.WIDTH(16)) dut16 (.clk(clk), .rst(rst), .bus(i16));
  alu_seq #(.WIDTH(8))  dut8  (.clk(clk), .rst(rst), .bus(i8));
  alu_seq #(.WIDTH(32)) dut32 (.clk(clk), .rst(rst), .bus(i32));

  always_comb begin
    o_rdy = i16.in_ready;  o_vld = i16.out_valid; o_res = 64'(i16.result);
    o_z   = i16.z; o_n = i16.n; o_c = i16.c; o_v = i16.v;
    case (sel)
      2'd1: begin
        o_rdy = i8.in_ready;  o_vld = i8.out_valid; o_res = 64'(i8.result);
        o_z   = i8.z; o_n = i8.n; o_c = i8.c; o_v = i8.v;
      end
      2'd2: begin
        o_rdy = i32.in_ready; o_vld = i32.out_valid; o_res = 64'(i32.result);
        o_z   = i32.z; o_n = i32.n; o_c = i32.c; o_v = i32.v;
      end
      default: ;
    endcase
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic int width_of(input logic [1:0] s);
    return (s == 2'd1) ? 8 : (s == 2'd2) ? 32 : 16;
  endfunction

  // Present one request, then scramble the bus and count cycles to out_valid.
  task automatic issue(input logic [2:0] op, input logic [63:0] av, input logic [63:0] bv,
                       output int lat);
    @(negedge clk);
    chk("rdy_before_issue", o_rdy, 1);
    op_s = op; a_s = av; b_s = bv; iv = 3'b001 << sel;
    @(negedge clk);
    iv = '0; a_s = ~av; b_s = ~bv ^ 64'h5a; op_s = ~op;
    lat = 1;
    while (!o_vld && lat < 200) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic run(input string tag, input logic [2:0] op, input logic [63:0] av,
                     input logic [63:0] bv, input int exp_lat, input logic [63:0] exp_r,
                     input logic exp_c, input logic exp_v);
    int lat;
    int w;
    w = width_of(sel);
    issue(op, av, bv, lat);
    chk({tag, "_lat"}, lat, exp_lat);
    chk({tag, "_res"}, o_res, exp_r);
    chk({tag, "_c"}, o_c, exp_c);
    chk({tag, "_v"}, o_v, exp_v);
    chk({tag, "_z"}, o_z, exp_r == 64'd0);
    chk({tag, "_n"}, o_n, exp_r[w-1]);
    @(negedge clk);
    chk({tag, "_pulse_end"}, o_vld, 0);
    chk({tag, "_rdy_after"}, o_rdy, 1);
  endtask

  // Hold in_valid high across three XOR requests; garbage on the bus while busy.
  task automatic queued();
    logic [63:0] exp_q[3];
    int          t_q[3];
    int          k, pulses, w;
    logic [63:0] mask;
    w = width_of(sel);
    mask = (64'd1 << w) - 64'd1;
    k = 0; pulses = 0;
    t_q = '{0, 0, 0};
    for (int cyc = 0; cyc < 30; cyc++) begin
      @(negedge clk);
      if (o_vld) begin
        if (pulses < 3) begin
          chk("xq_res", o_res, exp_q[pulses]);
          t_q[pulses] = cyc;
        end
        pulses++;
      end
      if (o_rdy) begin
        if (k < 3) begin
          a_s = 64'h0123456789abcdef >> (k * 4);
          b_s = 64'hfedcba9876543210 << k;
          op_s = XOR;
          iv = 3'b001 << sel;
          exp_q[k] = (a_s ^ b_s) & mask;
          k++;
        end else begin
          iv = '0;
        end
      end else begin
        a_s = {$urandom, $urandom};
        b_s = {$urandom, $urandom};
        op_s = ADD;
      end
    end
    iv = '0;
    chk("xq_count", pulses, 3);
    chk("xq_gap1", t_q[1] - t_q[0], 2);
    chk("xq_gap2", t_q[2] - t_q[1], 2);
  endtask

  initial begin
    int pulses;
    rst = 1'b1; iv = '0; a_s = '0; b_s = '0; op_s = '0; sel = 2'd0;
    repeat (2) @(negedge clk);
    chk("rst_rdy", o_rdy, 1);
    chk("rst_vld", o_vld, 0);
    chk("rst_res", o_res, 0);
    chk("rst_z", o_z, 1);
    chk("rst_n", o_n, 0);
    chk("rst_c", o_c, 0);
    chk("rst_v", o_v, 0);
    rst = 1'b0;

    // WIDTH = 16
    run("add_ovf",  ADD, 64'h7FFF, 64'h0001,  1, 64'h8000, 1'b0, 1'b1);
    run("add_cy",   ADD, 64'hFFFF, 64'h0001,  1, 64'h0000, 1'b1, 1'b0);
    run("sub_brw",  SUB, 64'h0003, 64'h0005,  1, 64'hFFFE, 1'b1, 1'b0);
    run("sub_eq",   SUB, 64'h1234, 64'h1234,  1, 64'h0000, 1'b0, 1'b0);
    run("and",      AND, 64'hF0F0, 64'hFF00,  1, 64'hF000, 1'b0, 1'b0);
    run("or",       OR,  64'hF0F0, 64'hFF00,  1, 64'hFFF0, 1'b0, 1'b0);
    run("shl4",     SHL, 64'h8001, 64'h0004,  4, 64'h0010, 1'b0, 1'b0);
    run("shr1",     SHR, 64'h0009, 64'h0001,  1, 64'h0004, 1'b1, 1'b0);
    run("shl0",     SHL, 64'hABCD, 64'h0010,  1, 64'hABCD, 1'b0, 1'b0);
    run("shr15",    SHR, 64'h8000, 64'h000F, 15, 64'h0001, 1'b0, 1'b0);
    run("mul_hi",   MUL, 64'h1234, 64'h0010, 16, 64'h2340, 1'b1, 1'b1);
    run("mul_lo",   MUL, 64'h00FF, 64'h0002, 16, 64'h01FE, 1'b0, 1'b0);

    // Reset in the 7th cycle of a multiply: no completion, reset outputs.
    @(negedge clk);
    op_s = MUL; a_s = 64'h1234; b_s = 64'h0010; iv = 3'b001;
    @(negedge clk);
    iv = '0;
    repeat (6) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("mrst_vld", o_vld, 0);
    chk("mrst_rdy", o_rdy, 1);
    chk("mrst_res", o_res, 0);
    chk("mrst_z", o_z, 1);
    chk("mrst_n", o_n, 0);
    chk("mrst_c", o_c, 0);
    chk("mrst_v", o_v, 0);
    @(negedge clk);
    rst = 1'b0;
    pulses = 0;
    repeat (20) begin
      @(negedge clk);
      if (o_vld) pulses++;
    end
    chk("mrst_no_pulse", pulses, 0);
    run("add_post_rst", ADD, 64'h0002, 64'h0003, 1, 64'h0005, 1'b0, 1'b0);
    queued();

    // WIDTH = 8
    sel = 2'd1;
    run("w8_mul",   MUL, 64'h0F, 64'h11, 8, 64'hFF, 1'b0, 1'b0);
    run("w8_mulov", MUL, 64'h10, 64'h10, 8, 64'h00, 1'b1, 1'b1);
    run("w8_shr7",  SHR, 64'h80, 64'h07, 7, 64'h01, 1'b0, 1'b0);
    run("w8_shl1",  SHL, 64'h81, 64'h09, 1, 64'h02, 1'b1, 1'b0);
    queued();

    // WIDTH = 32
    sel = 2'd2;
    run("w32_mul",  MUL, 64'h00010000, 64'h00010000, 32, 64'h00000000, 1'b1, 1'b1);
    run("w32_shl",  SHL, 64'h00000001, 64'h0000001F, 31, 64'h80000000, 1'b0, 1'b0);
    run("w32_add",  ADD, 64'hFFFFFFFF, 64'h00000001,  1, 64'h00000000, 1'b1, 1'b0);
    run("w32_sub",  SUB, 64'h80000000, 64'h00000001,  1, 64'h7FFFFFFF, 1'b0, 1'b1);
    queued();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
